seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/div_step.sv | 35 +++
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential restoring divider:
//   - state_e      : controller states (IDLE, RUN, DONE)
//   - DEF_DW/DEF_VW: default dividend/quotient and divisor/remainder widths
// -----------------------------------------------------------------------------
package seq_divider_pkg;

   localparam int DEF_DW = 8;
   localparam int DEF_VW = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// Ports:
//   rem_i  [VW:0]   partial remainder entering the step
//   bit_i           next dividend bit (MSB first)
//   dvs_i  [VW-1:0] divisor
//   rem_o  [VW:0]   partial remainder leaving the step
//   q_o             quotient bit produced by the step
// -----------------------------------------------------------------------------
module div_step #(
   parameter int VW = 4
) (
   input  logic [VW:0]   rem_i,
   input  logic          bit_i,
   input  logic [VW-1:0] dvs_i,
   output logic [VW:0]   rem_o,
   output logic          q_o
);

   localparam int RW = VW + 1;

   // Shift is kept one bit wider than the remainder so the compare sees every
   // bit; for a nonzero divisor the result always fits back into RW bits.
   logic [RW:0] sh;
   logic [RW:0] dvs_x;

   always_comb begin
      sh    = {rem_i, bit_i};
      dvs_x = {2'b00, dvs_i};
      q_o   = (sh >= dvs_x);
      rem_o = q_o ? RW'(sh - dvs_x) : sh[VW:0];
   end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned sequential restoring divider, one quotient bit per cycle, DW cycles.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 request; accepted when idle or done
//   dividend [DW-1:0]     sampled at accept
//   divisor  [VW-1:0]     sampled at accept
//   busy                  high while iterating
//   done                  one-cycle pulse when results update
//   quotient [DW-1:0]     held until next done
//   remainder[VW-1:0]     held until next done
//   div_by_zero           set with done when the sampled divisor was zero
// -----------------------------------------------------------------------------
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int VW = DEF_VW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dvd_q, dvd_d;      // dividend, shifted left each step
   logic [VW-1:0] dvs_q, dvs_d;
   logic [VW:0]   rem_q, rem_d;      // working partial remainder
   logic [DW-1:0] quo_q, quo_d;      // working quotient
   logic [DW-1:0] quotient_q, quotient_d;
   logic [VW-1:0] remainder_q, remainder_d;
   logic          dbz_q, dbz_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [VW:0]   step_rem;
   logic          step_q;

   div_step #(.VW(VW)) u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[DW-1]),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               rem_d   = '0;
               quo_d   = '0;
               cnt_d   = CW'(DW - 1);
               state_d = ST_RUN;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // start is deliberately not looked at here
            dvd_d = {dvd_q[DW-2:0], 1'b0};
            rem_d = step_rem;
            quo_d = {quo_q[DW-2:0], step_q};
            if (cnt_q == '0) begin
               state_d    = ST_DONE;
               done_d     = 1'b1;
               quotient_d = {quo_q[DW-2:0], step_q};
               // With a zero divisor every step sets its quotient bit, so the
               // quotient is naturally all-ones; only the remainder is forced.
               dbz_d       = (dvs_q == '0);
               remainder_d = (dvs_q == '0) ? '0 : step_rem[VW-1:0];
            end else begin
               cnt_d  = cnt_q - 1'b1;
               busy_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed-vector bench for seq_divider (DW=8, VW=4).
// -----------------------------------------------------------------------------
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy, done, div_by_zero;
   logic [7:0] quotient;
   logic [3:0] remainder;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.DW(8), .VW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one edge, then settle at the following negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // caller sits at a negedge; leaves at the negedge after the accept edge
   task automatic issue(input logic [7:0] a, input logic [3:0] b, input string tag);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      step();
      start    = 1'b0;
      dividend = 8'h00;
      divisor  = 4'h0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
   endtask

   // waits (bounded) for done; cyc0 = edges already elapsed since accept
   task automatic wait_done(input int cyc0, input int exp_lat, input string tag);
      int cyc;
      cyc = cyc0;
      while (cyc < 40) begin
         step();
         cyc++;
         if (busy && done) chk({tag, "_excl"}, {busy, done}, 2'b00);
         if (done) break;
      end
      chk({tag, "_lat"}, cyc, exp_lat);
   endtask

   task automatic check_res(input string tag, input logic [7:0] q, input logic [3:0] r,
                            input logic z);
      chk({tag, "_q"}, quotient, q);
      chk({tag, "_r"}, remainder, r);
      chk({tag, "_dbz"}, div_by_zero, z);
      chk({tag, "_busy0"}, busy, 0);
   endtask

   initial begin
      int pulses;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      @(negedge clk);
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);

      // reset wins over start
      start = 1'b1; dividend = 8'd200; divisor = 4'd7;
      step();
      chk("rst_prio_busy", busy, 0);
      start = 1'b0; rst = 1'b0;
      step();
      chk("idle_busy", busy, 0);

      // 200/7 then back-to-back 255/15 from the done cycle
      issue(8'd200, 4'd7, "d200_7");
      wait_done(0, 8, "d200_7");
      check_res("d200_7", 8'd28, 4'd4, 1'b0);
      issue(8'd255, 4'd15, "d255_15");
      chk("hold_q", quotient, 28);
      chk("hold_r", remainder, 4);
      wait_done(0, 8, "d255_15");
      check_res("d255_15", 8'd17, 4'd0, 1'b0);
      step();
      chk("done_pulse", done, 0);

      // divide by zero, then a normal op must clear the flag
      issue(8'd100, 4'd0, "d100_0");
      wait_done(0, 8, "d100_0");
      check_res("d100_0", 8'hFF, 4'd0, 1'b1);
      step();
      chk("dbz_hold", div_by_zero, 1);

      issue(8'd5, 4'd9, "d5_9");
      wait_done(0, 8, "d5_9");
      check_res("d5_9", 8'd0, 4'd5, 1'b0);
      step();

      issue(8'd255, 4'd1, "d255_1");
      wait_done(0, 8, "d255_1");
      check_res("d255_1", 8'd255, 4'd0, 1'b0);
      step();

      // start during RUN is ignored
      issue(8'd100, 4'd3, "d100_3");
      step();
      step();
      start = 1'b1; dividend = 8'd9; divisor = 4'd2;
      step();
      start = 1'b0;
      chk("ign_busy", busy, 1);
      wait_done(3, 8, "d100_3");
      check_res("d100_3", 8'd33, 4'd1, 1'b0);
      step();

      // reset mid-run aborts
      issue(8'd200, 4'd7, "abort");
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      chk("abort_dbz", div_by_zero, 0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) pulses++;
      end
      chk("abort_nodone", pulses, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
